// File: rtl/dmem_pkg.sv
// Shared types and decode helpers for the MEM-stage load/store unit.
// funct3 encodings follow inst_defs.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_X
  } size_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    logic        store;
  } resp_t;

  function automatic size_e size_of(
    input logic       we,
    input logic [2:0] f3
  );
    size_e s;
    s = SZ_X;
    if (we) begin
      case (f3)
        F3_SB:   s = SZ_B;
        F3_SH:   s = SZ_H;
        F3_SW:   s = SZ_W;
        default: s = SZ_X;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: s = SZ_B;
        F3_LH, F3_LHU: s = SZ_H;
        F3_LW:         s = SZ_W;
        default:       s = SZ_X;
      endcase
    end
    return s;
  endfunction

  function automatic logic fault_of(
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [32:0] span
  );
    size_e sz;
    logic  mis;
    logic  oor;
    sz  = size_of(we, f3);
    mis = (sz == SZ_H && addr[0]) ||
          (sz == SZ_W && addr[1:0] != 2'd0);
    // 33-bit compare so a window ending at 4 GiB cannot wrap
    oor = (addr < base) ||
          ({1'b0, addr} >= ({1'b0, base} + span));
    return (sz == SZ_X) || mis || oor;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order response buffer between the LSU S1 register and the core.
// Pointers wrap naturally because DEPTH is a power of two.
module resp_fifo
  import dmem_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = resp_t,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  T              mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && full && !pop))
        else $error("resp_fifo: push while full");
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Pipelined RV32 data memory: request -> S1 (read/check) -> response FIFO.
// Byte-lane writes land at the accept edge; loads extend in S1.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int          DEPTH      = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RESP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        resp_store
);

  localparam int          AW   = $clog2(DEPTH);
  localparam int          CW   = $clog2(RESP_DEPTH) + 1;
  localparam logic [32:0] SPAN = 33'(4 * DEPTH);

  logic [31:0] mem [DEPTH];

  logic          acc;
  logic          req_fault;
  size_e         req_sz;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wd;

  logic          s1_valid;
  logic [2:0]    s1_f3;
  logic [1:0]    s1_off;
  logic          s1_fault;
  logic          s1_store;
  logic [31:0]   s1_word;
  logic [31:0]   sh;

  resp_t         push_d;
  resp_t         head;
  logic [CW-1:0] f_count;
  logic          f_full;
  logic          f_empty;

  assign req_sz    = size_of(req_we, req_funct3);
  assign req_fault = fault_of(req_we, req_funct3, req_addr,
                              BASE_ADDR, SPAN);
  assign idx       = req_addr[AW+1:2];
  assign acc       = req_valid && req_ready;

  // Counts S1 as occupied so an accepted request always has a slot
  assign req_ready = !f_full &&
                     ((f_count + CW'(s1_valid)) < CW'(RESP_DEPTH));

  always_comb begin
    be = 4'b0000;
    wd = req_wdata;
    case (req_sz)
      SZ_B: begin
        be = 4'b0001 << req_addr[1:0];
        wd = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        be = 4'b0011 << req_addr[1:0];
        wd = {2{req_wdata[15:0]}};
      end
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!(acc && req_we && !req_fault)) be = 4'b0000;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (acc) s1_word <= mem[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_f3    <= '0;
      s1_off   <= '0;
      s1_fault <= 1'b0;
      s1_store <= 1'b0;
    end else begin
      s1_valid <= acc;
      if (acc) begin
        s1_f3    <= req_funct3;
        s1_off   <= req_addr[1:0];
        s1_fault <= req_fault;
        s1_store <= req_we;
      end
    end
  end

  assign sh = s1_word >> {s1_off, 3'b000};

  always_comb begin
    push_d       = '0;
    push_d.fault = s1_fault;
    push_d.store = s1_store;
    if (!s1_fault && !s1_store) begin
      case (s1_f3)
        F3_LB:   push_d.rdata = {{24{sh[7]}}, sh[7:0]};
        F3_LBU:  push_d.rdata = {24'd0, sh[7:0]};
        F3_LH:   push_d.rdata = {{16{sh[15]}}, sh[15:0]};
        F3_LHU:  push_d.rdata = {16'd0, sh[15:0]};
        F3_LW:   push_d.rdata = s1_word;
        default: push_d.rdata = '0;
      endcase
    end
  end

  resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .T     (resp_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_valid),
    .din   (push_d),
    .pop   (resp_valid && resp_ready),
    .dout  (head),
    .count (f_count),
    .full  (f_full),
    .empty (f_empty)
  );

  assign resp_valid = !f_empty;
  assign resp_rdata = f_empty ? 32'd0 : head.rdata;
  assign resp_fault = f_empty ? 1'b0 : head.fault;
  assign resp_store = f_empty ? 1'b0 : head.store;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed cases plus a random stream
// scored against a byte-array reference model.
module tb_dmem_lsu;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          RD    = 2;
  localparam int          NB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        resp_store;

  dmem_lsu #(
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE),
    .RESP_DEPTH (RD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .resp_store (resp_store)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic        store;
  } exp_t;

  logic [7:0]  ref_mem [NB];
  exp_t        q [$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          rand_rr = 0;
  logic [31:0] last_rdata = '0;
  logic        last_fault = 1'b0;
  logic        last_store = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: size from funct3, fault rules, little-endian byte array
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] a,
                                 input logic [31:0] d);
    exp_t   e;
    int     n;
    bit     sgn;
    longint ua;
    longint v;
    e.rdata = '0;
    e.store = we;
    n   = 0;
    sgn = 0;
    if (we) begin
      if (f3 == 3'd0) n = 1;
      else if (f3 == 3'd1) n = 2;
      else if (f3 == 3'd2) n = 4;
    end else begin
      if (f3 == 3'd0) begin n = 1; sgn = 1; end
      else if (f3 == 3'd4) n = 1;
      else if (f3 == 3'd1) begin n = 2; sgn = 1; end
      else if (f3 == 3'd5) n = 2;
      else if (f3 == 3'd2) n = 4;
    end
    ua = longint'({32'd0, a});
    e.fault = (n == 0) || (ua % n != 0) ||
              (ua < longint'({32'd0, BASE})) ||
              (ua >= longint'({32'd0, BASE}) + NB);
    if (!e.fault) begin
      ua = ua - longint'({32'd0, BASE});
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[ua + i] = d[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++)
          v = v | (longint'(ref_mem[ua + i]) << (8 * i));
        if (sgn && v[8*n-1]) v = v - (64'sd1 <<< (8 * n));
        e.rdata = v[31:0];
      end
    end
    return e;
  endfunction

  // Scoreboard: outstanding requests never exceed the buffer capacity
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("req_ready", req_ready, q.size() < RD);
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          chk("spurious_resp", 1, 0);
        end else begin
          chk("resp_rdata", resp_rdata, q[0].rdata);
          chk("resp_fault", resp_fault, q[0].fault);
          chk("resp_store", resp_store, q[0].store);
          void'(q.pop_front());
        end
        last_rdata = resp_rdata;
        last_fault = resp_fault;
        last_store = resp_store;
      end
      if (req_valid && req_ready)
        q.push_back(model(req_we, req_funct3, req_addr, req_wdata));
    end
  end

  task automatic send(input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok         = 0;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (rand_rr) resp_ready = ($urandom % 3) != 0;
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    else begin
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok         = 0;
    resp_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !resp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
    send(we, f3, a, d);
    drain();
  endtask

  logic [7:0]  pb0, pb2, pb3;
  logic [31:0] ra, rw;
  logic [2:0]  rf;
  logic        rwe;
  int          r;

  initial begin
    #2;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_resp_store", resp_store, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    resp_ready = 1'b1;

    // Fill every word so loads never see uninitialised memory
    for (int i = 0; i < DEPTH; i++)
      send(1'b1, 3'd2, BASE + 32'(4 * i), $urandom);
    drain();

    // SW then LW with latency check
    xfer(1'b1, 3'd2, BASE + 32'h10, 32'hDEAD_BEEF);
    chk("sw_store", last_store, 1);
    chk("sw_fault", last_fault, 0);
    send(1'b0, 3'd2, BASE + 32'h10, 32'd0);
    @(negedge clk);
    chk("lat_s1", resp_valid, 0);
    @(negedge clk);
    chk("lat_2edge", resp_valid, 1);
    drain();
    chk("lw_rdata", last_rdata, 32'hDEAD_BEEF);

    // SB then LB/LBU; neighbours untouched
    pb0 = ref_mem[32'h20];
    pb2 = ref_mem[32'h22];
    pb3 = ref_mem[32'h23];
    xfer(1'b1, 3'd0, BASE + 32'h21, 32'h1234_5680);
    xfer(1'b0, 3'd0, BASE + 32'h21, 32'd0);
    chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
    xfer(1'b0, 3'd4, BASE + 32'h21, 32'd0);
    chk("lbu_rdata", last_rdata, 32'h0000_0080);
    xfer(1'b0, 3'd2, BASE + 32'h20, 32'd0);
    chk("sb_lanes", last_rdata, {pb3, pb2, 8'h80, pb0});

    // Faults
    xfer(1'b0, 3'd2, BASE + 32'h02, 32'd0);
    chk("f_lw_mis", last_fault, 1);
    chk("f_lw_mis_d", last_rdata, 0);
    xfer(1'b1, 3'd1, BASE + 32'h03, 32'hFFFF_FFFF);
    chk("f_sh_mis", last_fault, 1);
    chk("f_sh_mis_d", last_rdata, 0);
    xfer(1'b0, 3'd2, BASE + 32'(NB), 32'd0);
    chk("f_oor", last_fault, 1);
    chk("f_oor_d", last_rdata, 0);
    xfer(1'b0, 3'd3, BASE + 32'h08, 32'd0);
    chk("f_f3", last_fault, 1);
    chk("f_f3_d", last_rdata, 0);
    xfer(1'b0, 3'd2, BASE + 32'h00, 32'd0);

    // Reset with two responses buffered
    resp_ready = 1'b0;
    send(1'b0, 3'd2, BASE + 32'h10, 32'd0);
    send(1'b0, 3'd2, BASE + 32'h14, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", resp_valid, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", resp_valid, 0);
    chk("rst_async_rdata", resp_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_valid", resp_valid, 0);
    @(posedge clk);
    #1;
    xfer(1'b0, 3'd2, BASE + 32'h10, 32'd0);
    chk("post_rst_sw", last_rdata, 32'hDEAD_BEEF);

    // Back-pressure and in-order return across pointer wrap
    resp_ready = 1'b0;
    send(1'b0, 3'd2, BASE + 32'h40, 32'd0);
    send(1'b0, 3'd2, BASE + 32'h44, 32'd0);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready_low", req_ready, 0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    for (int i = 0; i < 12; i++)
      send(1'b0, 3'd2, BASE + 32'(4 * ($urandom % DEPTH)), 32'd0);
    drain();

    // Random mixed stream
    rand_rr = 1;
    for (int k = 0; k < 10000; k++) begin
      r   = int'($urandom % 16);
      rwe = $urandom % 2;
      rf  = 3'($urandom % 8);
      rw  = $urandom;
      if (r == 0) ra = $urandom;
      else if (r == 1) ra = BASE + 32'(NB - 4 + int'($urandom % 8));
      else ra = BASE + 32'($urandom % NB);
      if (r >= 2 && r < 10) ra = ra & ~32'd3;
      send(rwe, rf, ra, rw);
      if ($urandom % 8 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rr = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised successor to the single-cycle data memory, for the pipelined core's MEM stage.
- Accepts one load or store per cycle over a valid/ready request channel.
- Performs RV32 byte/half/word access with alignment, range and funct3 checking.
- Returns every request's result (data or fault) in order over a valid/ready response channel, backed by a small response FIFO so the core may stall.

Parameters:
DEPTH, 256, number of 32-bit words; power of 2, >=4
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*DEPTH
RESP_DEPTH, 2, response FIFO entries; power of 2, >=2

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  request may be accepted this cycle
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32 load/store funct3 (inst_defs encodings)
req_addr  input  32  byte address
req_wdata  input  32  store data, low bytes used for SB/SH
resp_valid  output  1  response present
resp_ready  input  1  consumer takes response
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_fault  output  1  request was faulted, memory untouched
resp_store  output  1  response belongs to a store

Behaviour:
- Accept = req_valid & req_ready, at the rising edge. At most one request per cycle.
- Ordering: responses return strictly in acceptance order.
- Pipeline: accept edge N -> S1 register (valid, funct3, byte offset, fault, store flag, raw read word) -> FIFO push at edge N+1 -> resp_valid high from edge N+1.
  - Minimum latency is 2 edges; there is no bypass.
- Pop = resp_valid & resp_ready.
- req_ready = (fifo_count + s1_valid) < RESP_DEPTH.
  - A pop in the same cycle does not raise req_ready; it is conservative and derived from registered state only.
- Fault checks, combinational on the request:
  - Misaligned: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0. Byte accesses are never misaligned.
  - Out of range: addr < BASE_ADDR or addr >= BASE_ADDR+4*DEPTH.
  - Illegal funct3: loads 3/6/7; stores >=3.
  - Any fault -> no memory write, response carries fault=1 and rdata=0.
- Stores:
  - Byte-lane write at the accept edge. SW writes all 4 lanes; SH writes lanes {off, off+1}; SB writes lane off.
  - The store always produces a response with store=1 and rdata=0.
- Loads:
  - Raw word is read synchronously at the accept edge.
  - In S1, the selected byte/half is extracted at offset and extended: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
- Read-after-write: a store accepted at edge N is visible to a load accepted at edge N+1.
- FIFO:
  - Read/write pointers wrap mod RESP_DEPTH; count is 0..RESP_DEPTH.
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Push while full cannot occur because of the req_ready rule. Assert it never happens.
- Reset (async assert, sync-safe release):
  - s1_valid=0, FIFO empty, resp_valid=0, resp_rdata=0, resp_fault=0, resp_store=0.
  - req_ready=1 in the first cycle after release.
  - Memory contents are not reset.
  - Reset mid-operation drops all in-flight and buffered responses. Stores already written at a prior edge persist.
- resp_* outputs are held stable while resp_valid=1 and resp_ready=0.

Decomposition:
- Package dmem_pkg:
  - resp_t struct {rdata, fault, store}.
  - Access-size decode function from funct3.
  - Fault-check function.
  - Reuse the funct3 constants from inst_defs.
- Sub-module resp_fifo: parametrised by RESP_DEPTH and element type resp_t; clk/rst_n; push/pop, count, full/empty.
- Byte-lane write, S1 and extension logic stay in dmem_lsu.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10, resp_ready=1 -> store response (store=1, fault=0) then load response rdata=0xDEADBEEF. Load response resp_valid arrives 2 edges after its accept.
- SB 0x80 @0x21, then LB @0x21 and LBU @0x21 -> 0xFFFFFF80 then 0x00000080. Bytes 0x20/0x22/0x23 keep prior values.
- LW @0x02, SH @0x03, LW @BASE+4*DEPTH, load funct3=3 -> four responses with fault=1, rdata=0; memory unchanged.
- Back-to-back loads with resp_ready=0 -> req_ready drops after 2 accepts. Then raise resp_ready -> responses return in order, none lost or duplicated across FIFO pointer wrap (≥10 requests).
- Assert rst_n low with 2 responses buffered -> resp_valid=0 immediately. After release: req_ready=1, FIFO empty, a prior SW value is still readable.
- Random mixed stream of 10k requests vs. a byte-array reference model -> all rdata/fault/store fields match, and req_ready never exceeds capacity.
